perf_csr_responder: RTL and testbench
=====================================

Name: perf_csr_responder

Overview:
- Responder side of the core's performance-metric interface.
- Where the perf monitor produces events, this block counts them in 64-bit counters and answers CSR read requests from the core's Zicsr path with a valid/ready handshake, one request at a time.
- Sits beside the perf monitor inside Core; gated by the same perf_enable strap the testbench drives from the PERF_ENABLE plusarg.

Parameters:
- NUM_HPM, 4, number of hpmcounter event counters (1..29), mapped from index 3 upward.
- CNT_W, 64, counter width; counters wrap modulo 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- perf_enable  in  1  counting enable; when 0, all counters hold.
- ev_retire  in  1  one instruction retired this cycle (increments minstret).
- ev_hpm  in  NUM_HPM  per-counter event strobes; bit i increments hpmcounter(3+i).
- req_valid  in  1  CSR read request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  12  CSR address.
- resp_valid  out  1  response valid.
- resp_ready  in  1  requester accepts response.
- resp_data  out  32  read data.
- resp_err  out  1  address not implemented.

Behaviour:
Reset (asynchronous):
- All counters and resp_data = 0.
- resp_valid = 0, resp_err = 0, req_ready = 1, FSM = IDLE.

Address map:
- 0xB00 / 0xC00: mcycle/cycle low.
- 0xB02 / 0xC02: minstret/instret low.
- 0xB03+i / 0xC03+i: hpmcounter low, for i < NUM_HPM.
- Adding 0x080 to any of the above selects the high half.
- Any other address: resp_err = 1, resp_data = 0.

Counting:
- Every cycle with perf_enable = 1: mcycle += 1, minstret += ev_retire, hpm[i] += ev_hpm[i].
- Wrap from 2^64-1 to 0 with no flag.

FSM IDLE:
- req_ready = 1.
- On req_valid, register the decoded data and err from counter values as they stand before that edge's increment.
- Move to RESP; resp_valid = 1 on the next cycle, giving 1-cycle latency.

FSM RESP:
- req_ready = 0.
- resp_valid, resp_data and resp_err stay stable until resp_ready.
- On resp_valid & resp_ready, return to IDLE; req_ready = 1 in the following cycle, so there is no same-cycle back-to-back.

Boundary conditions:
- A request while in RESP is not accepted; the requester must hold req_valid.
- Counting continues during RESP and does not alter the held resp_data.
- Reset mid-transaction drops the response and clears the counters.
- perf_enable toggling mid-read has no effect on the data already captured.

Optional Feature:
Macro PERF_SNAPSHOT_EN.
- Defined:
  - A low-half read also captures the upper 32 bits of the same counter into a shadow register and records its index with a shadow-valid bit.
  - A following high-half read of the same counter returns the shadow and clears shadow-valid.
  - A high read with no matching valid shadow returns the live upper half.
  - Reset clears shadow-valid.
- Undefined: high-half reads always return the live upper bits, and no shadow logic is present.

Test Plan:
- Reset release, perf_enable = 1, 10 idle cycles, read 0xB00 -> resp_valid one cycle after the accept edge, resp_data = 10 (counting starts the first cycle after reset), resp_err = 0.
- perf_enable = 0 for 20 cycles, then 1, read 0xC00 twice 5 cycles apart -> second value minus first = 5 plus the handshake cycles between the two accepts; no increment during the disabled window.
- Pulse ev_retire 7 times and ev_hpm[1] 3 times, read 0xB02 and 0xB04 -> 7 and 3; 0xB03 -> 0.
- Read 0x7C0 -> resp_err = 1, resp_data = 0; hold resp_ready = 0 for 4 cycles -> response held stable and req_ready = 0 throughout.
- Force mcycle to 0x0000_0000_FFFF_FFFE, read 0xB00 then 0xB80 -> with PERF_SNAPSHOT_EN, high read = 0x0 (the shadow captured before the carry); without it, high read = 0x1.
- Assert rst while in RESP -> resp_valid drops immediately, req_ready = 1, and a subsequent 0xB00 read returns a small post-reset count.

Source files
------------

// File: rtl/perf_csr_responder.sv
// -----------------------------------------------------------------------------
// perf_csr_responder
//
// Responder side of the core's performance-metric interface. Counts perf
// events in CNT_W-bit counters (mcycle, minstret, hpmcounter3..) and answers
// CSR read requests, one at a time, over a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   perf_enable  counting enable; all counters hold while low
//   ev_retire    one instruction retired this cycle (minstret += 1)
//   ev_hpm       per-counter event strobes; bit i drives hpmcounter(3+i)
//   req_valid    CSR read request valid
//   req_ready    responder can accept a request (only while idle)
//   req_addr     12-bit CSR address
//   resp_valid   response valid, held until resp_ready
//   resp_ready   requester accepts the response
//   resp_data    32-bit read data (0 on error)
//   resp_err     set when the address decodes to no counter
//
// Address map: 0xB00/0xC00 cycle, 0xB02/0xC02 instret, 0xB03+i/0xC03+i
// hpmcounter(3+i); +0x080 selects the upper 32 bits.
//
// Optional macro PERF_SNAPSHOT_EN: a low-half read snapshots the upper half
// of the same counter, and the next matching high-half read returns that
// snapshot, so a low/high pair is coherent across a carry.
// -----------------------------------------------------------------------------
module perf_csr_responder #(
    parameter int NUM_HPM = 4,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               perf_enable,
    input  logic               ev_retire,
    input  logic [NUM_HPM-1:0] ev_hpm,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [11:0]        req_addr,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_data,
    output logic               resp_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;

    logic [CNT_W-1:0]  r_mcycle;
    logic [CNT_W-1:0]  r_minstret;
    logic [CNT_W-1:0]  r_hpm [NUM_HPM];

    logic [31:0]       r_resp_data;
    logic              r_resp_err;

    logic              w_bank_ok;
    logic              w_is_hi;
    logic [4:0]        w_idx;
    logic              w_hit;
    logic [CNT_W-1:0]  w_sel;
    logic [31:0]       w_sel_lo;
    logic [31:0]       w_sel_hi;
    logic [31:0]       w_rd_data;

    // Address decode: bits [6:5] must be zero, bit 7 picks the half,
    // bits [4:0] pick the counter within the machine/user bank.
    assign w_bank_ok = ((req_addr[11:8] == 4'hB) || (req_addr[11:8] == 4'hC))
                       && (req_addr[6:5] == 2'b00);
    assign w_is_hi   = req_addr[7];
    assign w_idx     = req_addr[4:0];

    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        if (w_bank_ok) begin
            if (w_idx == 5'd0) begin
                w_hit = 1'b1;
                w_sel = r_mcycle;
            end else if (w_idx == 5'd2) begin
                w_hit = 1'b1;
                w_sel = r_minstret;
            end else begin
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (w_idx == 5'(i + 3)) begin
                        w_hit = 1'b1;
                        w_sel = r_hpm[i];
                    end
                end
            end
        end
    end

    assign w_sel_lo = 32'(w_sel);
    assign w_sel_hi = 32'(w_sel >> 32);

`ifdef PERF_SNAPSHOT_EN
    logic        r_sh_valid;
    logic [4:0]  r_sh_idx;
    logic [31:0] r_sh_data;
    logic        w_sh_match;

    assign w_sh_match = r_sh_valid && (r_sh_idx == w_idx);

    always_comb begin
        w_rd_data = '0;
        if (w_hit) begin
            if (!w_is_hi)
                w_rd_data = w_sel_lo;
            else if (w_sh_match)
                w_rd_data = r_sh_data;
            else
                w_rd_data = w_sel_hi;
        end
    end

    // Shadow is only touched by accepted, implemented reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_valid <= 1'b0;
            r_sh_idx   <= '0;
            r_sh_data  <= '0;
        end else if (w_accept && w_hit) begin
            if (!w_is_hi) begin
                r_sh_valid <= 1'b1;
                r_sh_idx   <= w_idx;
                r_sh_data  <= w_sel_hi;
            end else if (w_sh_match) begin
                r_sh_valid <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        w_rd_data = '0;
        if (w_hit)
            w_rd_data = w_is_hi ? w_sel_hi : w_sel_lo;
    end
`endif

    // Request/response FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Response capture uses the counter values from before this edge's
    // increment, so the data reflects the cycle the request was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else if (w_accept) begin
            r_resp_data <= w_rd_data;
            r_resp_err  <= ~w_hit;
        end
    end

    assign resp_valid = (r_state == S_RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

    // Event counters; wrap silently modulo 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
            for (int i = 0; i < NUM_HPM; i++)
                r_hpm[i] <= '0;
        end else if (perf_enable) begin
            r_mcycle   <= r_mcycle + CNT_W'(1);
            r_minstret <= r_minstret + CNT_W'(ev_retire);
            for (int i = 0; i < NUM_HPM; i++)
                r_hpm[i] <= r_hpm[i] + CNT_W'(ev_hpm[i]);
        end
    end

endmodule

// File: tb/tb_perf_csr_responder.sv
// -----------------------------------------------------------------------------
// tb_perf_csr_responder
//
// Directed and randomized bench for perf_csr_responder. A reference model
// keeps plain 64-bit event totals and a shadow record, and every CSR read is
// predicted from them at the cycle the request is accepted.
// -----------------------------------------------------------------------------
module tb_perf_csr_responder;

    localparam int NUM_HPM = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               perf_enable = 1'b0;
    logic               ev_retire = 1'b0;
    logic [NUM_HPM-1:0] ev_hpm = '0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [11:0]        req_addr = '0;
    logic               resp_valid;
    logic               resp_ready = 1'b0;
    logic [31:0]        resp_data;
    logic               resp_err;

    int n_pass  = 0;
    int n_total = 0;

    perf_csr_responder #(.NUM_HPM(NUM_HPM), .CNT_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .perf_enable (perf_enable),
        .ev_retire   (ev_retire),
        .ev_hpm      (ev_hpm),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    // Reference totals: how many events of each kind have been counted
    longint unsigned m_cyc;
    longint unsigned m_ret;
    longint unsigned m_hpm [NUM_HPM];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc <= 0;
            m_ret <= 0;
            for (int i = 0; i < NUM_HPM; i++) m_hpm[i] <= 0;
        end else if (perf_enable) begin
            m_cyc <= m_cyc + 1;
            m_ret <= m_ret + 64'(ev_retire);
            for (int i = 0; i < NUM_HPM; i++) m_hpm[i] <= m_hpm[i] + 64'(ev_hpm[i]);
        end
    end

    // Shadow record of the last low-half read (used only with PERF_SNAPSHOT_EN)
    bit          sm_valid = 1'b0;
    int          sm_idx   = 0;
    logic [31:0] sm_data  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic longint unsigned cnt_of(input int n);
        if (n == 0) return m_cyc;
        if (n == 2) return m_ret;
        return m_hpm[n - 3];
    endfunction

    // Returns 1 and the counter number/half for an implemented address.
    function automatic bit decode(input logic [11:0] a, output int n, output bit hi);
        int lo;
        int off;
        lo  = int'(a) & 'hF7F;
        off = lo & 'h07F;
        hi  = a[7];
        n   = 0;
        if ((lo & 'hF00) != 'hB00 && (lo & 'hF00) != 'hC00) return 1'b0;
        if (off == 0 || off == 2 || (off >= 3 && off < 3 + NUM_HPM)) begin
            n = off;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic predict(input logic [11:0] a, output logic [31:0] ed, output logic ee);
        int n;
        bit hi;
        longint unsigned v;
        ed = '0;
        ee = 1'b1;
        if (decode(a, n, hi)) begin
            v  = cnt_of(n);
            ee = 1'b0;
            if (!hi) begin
                ed = v[31:0];
`ifdef PERF_SNAPSHOT_EN
                sm_valid = 1'b1;
                sm_idx   = n;
                sm_data  = v[63:32];
`endif
            end else begin
                ed = v[63:32];
`ifdef PERF_SNAPSHOT_EN
                if (sm_valid && sm_idx == n) begin
                    ed       = sm_data;
                    sm_valid = 1'b0;
                end
`endif
            end
        end
    endtask

    // One full transaction, entered and left at a falling edge. The response
    // is left unaccepted for 'hold' cycles while a second request is pending.
    task automatic do_read(input logic [11:0] addr, input int hold, input bit chk,
                           output logic [31:0] d, output logic e);
        logic [31:0] ed;
        logic        ee;
        int          guard;
        req_valid = 1'b1;
        req_addr  = addr;
        guard     = 0;
        d         = '0;
        e         = 1'b0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        check("idle_no_resp", 32'(resp_valid), 32'd0);
        predict(addr, ed, ee);
        @(negedge clk);
        check("resp_valid_1cyc", 32'(resp_valid), 32'd1);
        check("busy_not_ready", 32'(req_ready), 32'd0);
        d = resp_data;
        e = resp_err;
        if (chk) begin
            check("resp_data", resp_data, ed);
            check("resp_err", 32'(resp_err), 32'(ee));
        end
        req_addr = addr ^ 12'h001;
        for (int k = 0; k < hold; k++) begin
            perf_enable = ~perf_enable;
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_not_ready", 32'(req_ready), 32'd0);
            check("hold_data", resp_data, d);
            check("hold_err", 32'(resp_err), 32'(e));
            if (chk) check("hold_data_ref", resp_data, ed);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_hs_valid", 32'(resp_valid), 32'd0);
        check("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, d1;
        logic        e0, e1;
        logic [11:0] a;
        int          idx_tab [6] = '{0, 2, 3, 4, 5, 6};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);

        // Counting starts on the first edge after reset release
        rst = 1'b0;
        perf_enable = 1'b1;
        repeat (10) @(negedge clk);
        do_read(12'hB00, 0, 1'b1, d0, e0);
        check("mcycle_10", d0, 32'd10);
        check("mcycle_10_err", 32'(e0), 32'd0);

        // Disabled window holds all counts
        perf_enable = 1'b0;
        do_read(12'hC00, 0, 1'b1, d0, e0);
        repeat (20) @(negedge clk);
        do_read(12'hC00, 0, 1'b1, d1, e1);
        check("disabled_hold", d1, d0);

        // Two reads 5 idle cycles apart: 5 + 2 handshake cycles between accepts
        perf_enable = 1'b1;
        do_read(12'hC00, 0, 1'b1, d0, e0);
        repeat (5) @(negedge clk);
        do_read(12'hC00, 0, 1'b1, d1, e1);
        check("cycle_delta", d1 - d0, 32'd7);

        // Event strobes
        for (int i = 0; i < 7; i++) begin
            ev_retire = 1'b1;
            ev_hpm    = (i < 3) ? 4'b0010 : 4'b0000;
            @(negedge clk);
        end
        ev_retire = 1'b0;
        ev_hpm    = '0;
        do_read(12'hB02, 0, 1'b1, d0, e0);
        check("minstret_7", d0, 32'd7);
        do_read(12'hB04, 0, 1'b1, d0, e0);
        check("hpm4_3", d0, 32'd3);
        do_read(12'hB03, 0, 1'b1, d0, e0);
        check("hpm3_0", d0, 32'd0);

        // Unimplemented address with a stalled response
        do_read(12'h7C0, 4, 1'b1, d0, e0);
        check("bad_addr_data", d0, 32'd0);
        check("bad_addr_err", 32'(e0), 32'd1);
        perf_enable = 1'b1;

        // Randomized traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(1, 6)) begin
                perf_enable = ($urandom_range(0, 3) != 0);
                ev_retire   = 1'($urandom);
                ev_hpm      = NUM_HPM'($urandom);
                @(negedge clk);
            end
            ev_retire = 1'b0;
            ev_hpm    = '0;
            case ($urandom_range(0, 3))
                0, 1: a = (($urandom_range(0, 1) != 0) ? 12'hB00 : 12'hC00)
                          + 12'(idx_tab[$urandom_range(0, 5)]);
                2:    a = 12'hB80 + 12'(idx_tab[$urandom_range(0, 5)]);
                default: a = 12'($urandom);
            endcase
            do_read(a, $urandom_range(0, 2), 1'b1, d0, e0);
        end

        // Carry between a low and a high read of mcycle
        perf_enable = 1'b1;
        @(negedge clk);
        force dut.r_mcycle = 64'h0000_0000_FFFF_FFFE;
        @(negedge clk);
        release dut.r_mcycle;
        do_read(12'hB00, 0, 1'b0, d0, e0);
        do_read(12'hB80, 0, 1'b0, d1, e1);
`ifdef PERF_SNAPSHOT_EN
        check("carry_hi_snapshot", d1, 32'd0);
`else
        check("carry_hi_live", d1, 32'd1);
`endif
        check("carry_hi_err", 32'(e1), 32'd0);

        // Reset while a response is pending
        req_valid = 1'b1;
        req_addr  = 12'hB02;
        check("pre_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_resp", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_drop_valid", 32'(resp_valid), 32'd0);
        check("rst_drop_ready", 32'(req_ready), 32'd1);
        sm_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_read(12'hB00, 0, 1'b1, d0, e0);
        check("post_rst_mcycle", d0, 32'd3);
        do_read(12'hB02, 0, 1'b1, d0, e0);
        check("post_rst_minstret", d0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
